// File: rtl/matrix_scan_param_if.sv
// Signal bundle between the HUB75 scan controller (master) and the framebuffer/pin-driver side (slave).
// dim_level exists only when MATRIX_SCAN_GLOBAL_DIM_EN is defined.
interface matrix_scan_param_if #(
    parameter int PIXEL_WIDTH     = 64,
    parameter int ROW_ADDR_BITS   = 4,
    parameter int BRIGHTNESS_BITS = 8
);
    localparam int COL_W = $clog2(PIXEL_WIDTH);

    logic                       enable;
`ifdef MATRIX_SCAN_GLOBAL_DIM_EN
    logic [7:0]                 dim_level;
`endif
    logic [COL_W-1:0]           column_address;
    logic [ROW_ADDR_BITS-1:0]   row_address;
    logic [ROW_ADDR_BITS-1:0]   row_address_active;
    logic [BRIGHTNESS_BITS-1:0] brightness_mask;
    logic [BRIGHTNESS_BITS-1:0] brightness_mask_active;
    logic                       clk_pixel_load;
    logic                       clk_pixel;
    logic                       row_latch;
    logic                       output_enable;
    logic                       frame_start;

    modport master (
        input  enable,
`ifdef MATRIX_SCAN_GLOBAL_DIM_EN
        input  dim_level,
`endif
        output column_address, row_address, row_address_active,
        output brightness_mask, brightness_mask_active,
        output clk_pixel_load, clk_pixel, row_latch, output_enable, frame_start
    );

    modport slave (
        output enable,
`ifdef MATRIX_SCAN_GLOBAL_DIM_EN
        output dim_level,
`endif
        input  column_address, row_address, row_address_active,
        input  brightness_mask, brightness_mask_active,
        input  clk_pixel_load, clk_pixel, row_latch, output_enable, frame_start
    );
endinterface

// File: rtl/matrix_scan_param.sv
// HUB75 row/bit-plane scan controller: shifts row N+1 while row N's binary-weighted OE window runs.
// Optional global dimming PWM on output_enable when MATRIX_SCAN_GLOBAL_DIM_EN is defined.
module matrix_scan_param #(
    parameter int PIXEL_WIDTH     = 64,
    parameter int ROW_ADDR_BITS   = 4,
    parameter int BRIGHTNESS_BITS = 8,
    parameter int OE_BASE_CYCLES  = 8,
    parameter int BLANK_CYCLES    = 2
) (
    input  logic                clk_in,
    input  logic                reset,
    matrix_scan_param_if.master bus
);
    localparam int COL_W = $clog2(PIXEL_WIDTH);
    localparam int OE_W  = $clog2(OE_BASE_CYCLES << (BRIGHTNESS_BITS-1)) + 1;
    localparam int BLK_W = $clog2(BLANK_CYCLES + 1);
    localparam logic [COL_W-1:0]           COL_LAST = COL_W'(PIXEL_WIDTH-1);
    localparam logic [BRIGHTNESS_BITS-1:0] MASK_ONE = BRIGHTNESS_BITS'(1);
    localparam logic [BRIGHTNESS_BITS-1:0] MASK_MSB = MASK_ONE << (BRIGHTNESS_BITS-1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WAIT, S_LATCH} state_t;

    state_t                     r_state, w_next;
    logic [COL_W-1:0]           r_col;
    logic [ROW_ADDR_BITS-1:0]   r_row, r_row_act;
    logic [BRIGHTNESS_BITS-1:0] r_mask, r_mask_act;
    logic                       r_clk_pixel, r_frame_start;
    logic [BLK_W-1:0]           r_blank;
    logic [OE_W-1:0]            r_on;
    logic [OE_W-1:0]            w_on_load;
    logic                       w_load, w_latch, w_oe_free, w_oe_win;

    assign w_load   = (r_state == S_SHIFT);
    assign w_latch  = (r_state == S_LATCH);
    assign w_oe_win = (r_blank == '0) && (r_on != '0);
    // Engine is idle in the next cycle, so a latch issued then never overlaps a lit window.
    // clk_pixel in that cycle mirrors this cycle's load, which is always low in WAIT.
    assign w_oe_free = (r_blank == '0) && (r_on <= OE_W'(1));

    always_ff @(posedge clk_in) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.enable) w_next = S_SHIFT;
            S_SHIFT: if (r_col == '0) w_next = S_WAIT;
            S_WAIT:  if (w_oe_free) w_next = S_LATCH;
            S_LATCH: w_next = bus.enable ? S_SHIFT : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // One-hot plane mask selects the on-time OE_BASE_CYCLES << k.
    always_comb begin
        w_on_load = '0;
        for (int i = 0; i < BRIGHTNESS_BITS; i++)
            if (r_mask[i]) w_on_load = OE_W'(OE_BASE_CYCLES) << i;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_col         <= COL_LAST;
            r_row         <= '0;
            r_row_act     <= '0;
            r_mask        <= MASK_MSB;
            r_mask_act    <= '0;
            r_clk_pixel   <= 1'b0;
            r_frame_start <= 1'b0;
            r_blank       <= '0;
            r_on          <= '0;
        end else begin
            r_clk_pixel   <= w_load;
            r_frame_start <= w_latch && (r_row == '0) && (r_mask == MASK_MSB);
            if (w_load && r_col != '0) r_col <= r_col - COL_W'(1);
            if (w_latch) begin
                r_col      <= COL_LAST;
                r_row_act  <= r_row;
                r_mask_act <= r_mask;
                if (r_mask == MASK_ONE) begin
                    r_mask <= MASK_MSB;
                    r_row  <= r_row + ROW_ADDR_BITS'(1);
                end else begin
                    r_mask <= r_mask >> 1;
                end
                r_blank <= BLK_W'(BLANK_CYCLES);
                r_on    <= w_on_load;
            end else if (r_blank != '0) begin
                r_blank <= r_blank - BLK_W'(1);
            end else if (r_on != '0) begin
                r_on <= r_on - OE_W'(1);
            end
        end
    end

`ifdef MATRIX_SCAN_GLOBAL_DIM_EN
    logic [7:0] r_dim_cnt;
    always_ff @(posedge clk_in) begin
        if (reset) r_dim_cnt <= '0;
        else       r_dim_cnt <= r_dim_cnt + 8'd1;
    end
    assign bus.output_enable = w_oe_win && (r_dim_cnt < bus.dim_level);
`else
    assign bus.output_enable = w_oe_win;
`endif

    assign bus.column_address         = r_col;
    assign bus.row_address            = r_row;
    assign bus.row_address_active     = r_row_act;
    assign bus.brightness_mask        = r_mask;
    assign bus.brightness_mask_active = r_mask_act;
    assign bus.clk_pixel_load         = w_load;
    assign bus.clk_pixel              = r_clk_pixel;
    assign bus.row_latch              = w_latch;
    assign bus.frame_start            = r_frame_start;
endmodule

// File: tb/tb_matrix_scan_param.sv
// Random enable/reset stimulus against a timestamp-schedule model of the scan controller.
// Exercises dim_level as well when MATRIX_SCAN_GLOBAL_DIM_EN is defined.
module tb_matrix_scan_param;
    localparam int PW  = 8;
    localparam int RB  = 2;
    localparam int BB  = 2;
    localparam int OEB = 4;
    localparam int BLK = 2;
    localparam int NR  = 1 << RB;

    logic clk_in = 1'b0;
    logic reset;
    always #5 clk_in = ~clk_in;

    matrix_scan_param_if #(.PIXEL_WIDTH(PW), .ROW_ADDR_BITS(RB), .BRIGHTNESS_BITS(BB)) bus();

    matrix_scan_param #(
        .PIXEL_WIDTH(PW), .ROW_ADDR_BITS(RB), .BRIGHTNESS_BITS(BB),
        .OE_BASE_CYCLES(OEB), .BLANK_CYCLES(BLK)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    int n_chk = 0, n_pass = 0, cyc = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    endtask

    function automatic int row_of(input int n);
        return (n / BB) % NR;
    endfunction

    function automatic int plane_of(input int n);
        return BB - 1 - (n % BB);
    endfunction

    // Schedule model: a row in progress has a shift start S and a latch time;
    // each latch opens an OE window [lo, hi]; latch count n drives row/plane.
    bit m_run, m_prev_load, m_fs_ok;
    int m_S, m_latch, m_n, m_lastL, m_lo, m_hi, m_dim, dl;
    bit e_load, e_latch, e_win, e_oe, e_fs, en, r;
    int e_col, len;

    task automatic m_reset();
        m_run = 0; m_prev_load = 0; m_fs_ok = 0;
        m_S = 0; m_latch = -100; m_n = 0; m_lastL = -100;
        m_lo = -100; m_hi = -100; m_dim = 0;
    endtask

    task automatic m_start(input int s);
        m_run   = 1;
        m_S     = s;
        m_latch = (s + PW + 1 > m_hi + 1) ? s + PW + 1 : m_hi + 1;
    endtask

    initial begin
        reset = 1'b1; bus.enable = 1'b0; en = 0; r = 1; dl = 255;
`ifdef MATRIX_SCAN_GLOBAL_DIM_EN
        bus.dim_level = 8'(dl);
`endif
        m_reset();
        @(posedge clk_in);
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk_in);
            e_load  = m_run && cyc >= m_S && cyc < m_S + PW;
            e_col   = !m_run ? PW - 1 : ((cyc < m_S + PW) ? PW - 1 - (cyc - m_S) : 0);
            e_latch = m_run && cyc == m_latch;
            e_win   = cyc >= m_lo && cyc <= m_hi;
`ifdef MATRIX_SCAN_GLOBAL_DIM_EN
            e_oe    = e_win && (m_dim < dl);
`else
            e_oe    = e_win;
`endif
            e_fs    = (cyc == m_lastL + 1) && m_fs_ok;

            chk("column_address", int'(bus.column_address), e_col);
            chk("clk_pixel_load", int'(bus.clk_pixel_load), int'(e_load));
            chk("clk_pixel", int'(bus.clk_pixel), int'(m_prev_load));
            chk("row_latch", int'(bus.row_latch), int'(e_latch));
            chk("output_enable", int'(bus.output_enable), int'(e_oe));
            chk("frame_start", int'(bus.frame_start), int'(e_fs));
            chk("row_address", int'(bus.row_address), row_of(m_n));
            chk("brightness_mask", int'(bus.brightness_mask), 1 << plane_of(m_n));
            chk("row_address_active", int'(bus.row_address_active),
                (m_n == 0) ? 0 : row_of(m_n - 1));
            chk("brightness_mask_active", int'(bus.brightness_mask_active),
                (m_n == 0) ? 0 : 1 << plane_of(m_n - 1));

            if (k < 3) begin
                r = 1; en = 0;
            end else if (k < 400) begin
                r = 0; en = 1;
            end else begin
                r = 0;
                if ($urandom_range(0, 99) < 4) en = !en;
                if (k >= 2500 && ((e_win && $urandom_range(0, 19) == 0) ||
                                  $urandom_range(0, 499) == 0)) r = 1;
            end
`ifdef MATRIX_SCAN_GLOBAL_DIM_EN
            if (k % 512 == 0) begin
                case ($urandom_range(0, 3))
                    0:       dl = 0;
                    1:       dl = 128;
                    2:       dl = 255;
                    default: dl = $urandom_range(0, 255);
                endcase
                bus.dim_level = 8'(dl);
            end
`endif
            reset = r; bus.enable = en;

            m_prev_load = e_load;
            if (r) begin
                m_reset();
            end else begin
                m_dim = (m_dim + 1) % 256;
                if (e_latch) begin
                    len     = OEB << plane_of(m_n);
                    m_fs_ok = (row_of(m_n) == 0) && (plane_of(m_n) == BB - 1);
                    m_lastL = cyc;
                    m_lo    = cyc + BLK + 1;
                    m_hi    = cyc + BLK + len;
                    m_n++;
                    if (en) m_start(cyc + 1);
                    else    m_run = 0;
                end else if (!m_run && en) begin
                    m_start(cyc + 1);
                end
            end
            cyc++;
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/matrix_scan_param.md
# matrix_scan_param

Parametrised HUB75 row/bit-plane scan controller; the next-generation scan engine for the LED panel pipeline. Generates column and row addressing, pixel-load and pixel-clock strobes, row latch and binary-weighted output-enable windows for any panel width, subpanel height and colour depth. Shifting of the next row overlaps the previous plane's OE window. Sits between the framebuffer read port, which is driven by `column_address`/`row_address`/`brightness_mask`, and the panel pin driver.

## Interface
- `PIXEL_WIDTH`, 64: columns per row; ≥2.
- `ROW_ADDR_BITS`, 4: subpanel row address width; 2^N rows.
- `BRIGHTNESS_BITS`, 8: bit planes per pixel; ≥1.
- `OE_BASE_CYCLES`, 8: OE on-time of LSB plane; plane k lasts `OE_BASE_CYCLES << k`.
- `BLANK_CYCLES`, 2: forced OE-low cycles after each latch; ≥1.
- `clk_in` in 1: sole clock; everything on posedge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: run scan.
- `column_address` out clog2(PIXEL_WIDTH): column being shifted.
- `row_address` out ROW_ADDR_BITS: row being shifted.
- `row_address_active` out ROW_ADDR_BITS: row currently latched/lit.
- `brightness_mask` out BRIGHTNESS_BITS: one-hot plane being shifted.
- `brightness_mask_active` out BRIGHTNESS_BITS: one-hot plane currently lit.
- `clk_pixel_load` out 1: pixel data fetch strobe.
- `clk_pixel` out 1: panel shift strobe; `clk_pixel_load` delayed 1 cycle.
- `row_latch` out 1: single-cycle latch pulse.
- `output_enable` out 1: high = LEDs lit.
- `frame_start` out 1: single-cycle pulse on the latch of row 0, MSB plane.

## Operation
- No gating of `clk_in`; all strobes are registered-state decodes, and the pin driver forms physical clocks.
- FSM states:
  - IDLE → SHIFT when `enable`=1.
  - SHIFT runs exactly PIXEL_WIDTH cycles with `clk_pixel_load`=1; `column_address` steps PIXEL_WIDTH-1 down to 0, then → WAIT.
  - WAIT → LATCH when `clk_pixel`=0 and the OE engine is idle (blank and on-time both expired).
  - LATCH lasts 1 cycle with `row_latch`=1.
  - After LATCH: → SHIFT if `enable`=1, else → IDLE. `column_address` reloads PIXEL_WIDTH-1.
- At LATCH:
  - `*_active` take `current`.
  - If `brightness_mask`==1, mask reloads to 1<<(BRIGHTNESS_BITS-1) and `row_address` increments, wrapping 2^N-1→0.
  - Otherwise the mask shifts right by 1.
- `frame_start` pulses the cycle after a LATCH whose latched row is 0 and latched plane is the MSB.
- OE engine: loaded on LATCH. It holds OE low for BLANK_CYCLES, then high for `OE_BASE_CYCLES << k`, where k is the bit index of `brightness_mask_active`, then goes idle. Counter width is clog2(OE_BASE_CYCLES<<(BRIGHTNESS_BITS-1))+1, with no overflow.
- `enable` dropped mid-row: the current SHIFT/WAIT/LATCH completes and the OE window runs to completion, then IDLE. Addresses are retained, and resume continues the sequence.
- Reset mid-operation: all outputs take reset values on the next edge, and the OE engine goes idle.

## Timing
- Reset values:
  - `column_address`=PIXEL_WIDTH-1.
  - `row_address`=0 and `row_address_active`=0.
  - `brightness_mask`=MSB one-hot and `brightness_mask_active`=0.
  - `clk_pixel_load`, `clk_pixel`, `row_latch`, `output_enable` and `frame_start` are all 0.
- From `enable` rising in IDLE at edge E, the first `clk_pixel_load` is high in cycle E+1.
- The last `clk_pixel_load` is at cycle N and its `clk_pixel` at N+1. The earliest `row_latch` is at N+2.
- After latch at cycle L: OE is low for L+1..L+BLANK_CYCLES, high for the next `OE_BASE_CYCLES<<k` cycles, and the next latch is no earlier than the first cycle after OE falls.
- `output_enable` is never high during `row_latch` or in the cycle after it.

## Configuration
- `MATRIX_SCAN_GLOBAL_DIM_EN` defined:
  - Adds input `dim_level`[7:0] and an 8-bit free-running `dim_cnt`, reset to 0.
  - `output_enable` = OE window && (`dim_cnt` < `dim_level`).
  - `dim_level`=0 gives dark; 255 gives 255/256 duty.
  - Window lengths and latch timing are unchanged.
- Undefined: no port, and `output_enable` = OE window.

## Test plan
- Params PIXEL_WIDTH=8, ROW_ADDR_BITS=2, BRIGHTNESS_BITS=2, OE_BASE_CYCLES=4, BLANK_CYCLES=2.
  - Reset then `enable`=1 → 8 load strobes with columns 7..0; `clk_pixel` lags 1 cycle; `row_latch` 2 cycles after the last load; `brightness_mask_active`=2.
  - After the first latch at L → OE low L+1..L+2, high L+3..L+10 (8 cycles); second latch at L+11; mask_active=1 with OE high for 4 cycles.
  - Run 8 latches → `row_address_active` sequence 0,0,1,1,2,2,3,3; next latch wraps to row 0 with a `frame_start` pulse.
  - Drop `enable` mid-SHIFT → row completes, one latch, OE window finishes, FSM idles; re-enable → the next row/plane continues.
  - Assert `reset` during an OE-high cycle → all outputs at reset values the next cycle.
- With `MATRIX_SCAN_GLOBAL_DIM_EN`:
  - `dim_level`=0 → OE never high.
  - `dim_level`=128 over 256 cycles of continuous window → OE high exactly 128 cycles.
